// File: rtl/csr_pkg.sv
// CSR counter file shared package: CSR addresses,
// op encoding, address decode and read-modify-write helper.
package csr_pkg;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPM_BASE     = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMH_BASE    = 12'hB80;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_HPM_BASE      = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_TIMEH         = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_HPMH_BASE     = 12'hC80;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    K_NONE,
    K_CNT,
    K_INH,
    K_SCR
  } csr_kind_e;

  typedef struct packed {
    csr_kind_e  kind;
    logic       ro;
    logic       hi;
    logic [4:0] idx;
  } csr_dec_t;

  // idx is the counter slot (0 cycle, 2 instret, 3.. hpm).
  // The user-level time CSR aliases slot 0.
  function automatic csr_dec_t csr_decode(
    input logic [11:0] a,
    input int          nhpm
  );
    csr_dec_t d;
    d = '{kind: K_NONE, ro: 1'b0, hi: 1'b0, idx: 5'd0};
    if (a == CSR_MCOUNTINHIBIT) begin
      d.kind = K_INH;
    end else if (a == CSR_MSCRATCH) begin
      d.kind = K_SCR;
    end else if ((a[11:8] == 4'hB || a[11:8] == 4'hC)
                 && a[6:5] == 2'b00) begin
      d.ro  = (a[11:8] == 4'hC);
      d.hi  = a[7];
      d.idx = a[4:0];
      if (a[4:0] == 5'd1) begin
        if (d.ro) begin
          d.idx  = 5'd0;
          d.kind = K_CNT;
        end
      end else if (a[4:0] == 5'd0 || a[4:0] == 5'd2) begin
        d.kind = K_CNT;
      end else if (int'(a[4:0]) < 3 + nhpm) begin
        d.kind = K_CNT;
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] csr_apply(
    input csr_op_e     op,
    input logic [31:0] old,
    input logic [31:0] wd
  );
    logic [31:0] r;
    r = old;
    case (op)
      CSR_RW:  r = wd;
      CSR_RS:  r = old | wd;
      CSR_RC:  r = old & ~wd;
      default: r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csr_counter_file_counter.sv
// One wrapping counter with independent 32-bit half loads.
// Ports: clk, rst, inc, wr_lo, wr_hi, wdata -> count.
module csr_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] lo_val;
  logic [63:0]      hi_val;

  assign lo_val = {count[CNT_W-1:32], wdata};
  assign hi_val = {wdata, count[31:0]};

  // A write always wins over the increment in its cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wr_lo) begin
      count <= lo_val;
    end else if (wr_hi) begin
      count <= hi_val[CNT_W-1:0];
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/csr_counter_file.sv
// Machine/user counter CSRs, mcountinhibit and mscratch.
// Ports: csr_en/op/addr/wdata/src_zero, retire, hpm_event -> csr_rdata, csr_illegal.
module csr_counter_file
  import csr_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 64,
  parameter int NUM_HPM = 2,
  parameter int HW      = (NUM_HPM > 0) ? NUM_HPM : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_src_zero,
  input  logic            retire,
  input  logic [HW-1:0]   hpm_event,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal
);

  localparam int NC = 3 + NUM_HPM;

  // Writable inhibit bits: CY (0), IR (2), HPM3..HPM(2+NUM_HPM).
  localparam logic [31:0] INH_MASK =
    32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  csr_op_e     op;
  csr_dec_t    dec;
  logic        active;
  logic        wr_req;
  logic        illegal;
  logic        do_wr;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic [31:0] inh_q;
  logic [31:0] scratch_q;
  logic [63:0] sel_cnt;

  logic [CNT_W-1:0] counts [NC];

  assign op  = csr_op_e'(csr_op);
  assign dec = csr_decode(csr_addr, NUM_HPM);

  assign active = csr_en && (op != CSR_NONE);

  // Set/clear with a zero source is a pure read.
  assign wr_req = (op == CSR_RW)
               || (((op == CSR_RS) || (op == CSR_RC))
                   && !csr_src_zero);

  assign illegal = active
                && ((dec.kind == K_NONE)
                    || (dec.ro && wr_req));

  assign do_wr = active && wr_req && !illegal;

  assign csr_illegal = illegal;

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NC; i++) begin
      if (dec.idx == 5'(i)) begin
        sel_cnt = 64'(counts[i]);
      end
    end
  end

  always_comb begin
    old_val = '0;
    unique case (1'b1)
      dec.kind == K_CNT: old_val = dec.hi ? sel_cnt[63:32]
                                          : sel_cnt[31:0];
      dec.kind == K_INH: old_val = inh_q;
      dec.kind == K_SCR: old_val = scratch_q;
      default:           old_val = '0;
    endcase
  end

  assign csr_rdata = XLEN'(old_val);
  assign new_val   = csr_apply(op, old_val, 32'(csr_wdata));

  always_ff @(posedge clk) begin
    if (rst) begin
      inh_q     <= '0;
      scratch_q <= '0;
    end else if (do_wr) begin
      if (dec.kind == K_INH) begin
        inh_q <= new_val & INH_MASK;
      end
      if (dec.kind == K_SCR) begin
        scratch_q <= new_val;
      end
    end
  end

  for (genvar i = 0; i < NC; i++) begin : g_cnt
    if (i == 1) begin : g_gap
      assign counts[i] = '0;
    end else begin : g_ctr
      logic ev;
      logic inc;
      logic wr_lo;
      logic wr_hi;
      logic hit;

      if (i == 0) begin : g_cy
        assign ev = 1'b1;
      end else if (i == 2) begin : g_ir
        assign ev = retire;
      end else begin : g_hpm
        assign ev = hpm_event[i-3];
      end

      assign inc   = ev && !inh_q[i];
      assign hit   = do_wr && (dec.kind == K_CNT)
                  && (dec.idx == 5'(i));
      assign wr_lo = hit && !dec.hi;
      assign wr_hi = hit && dec.hi;

      csr_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc),
        .wr_lo(wr_lo),
        .wr_hi(wr_hi),
        .wdata(new_val),
        .count(counts[i])
      );
    end
  end

endmodule

// File: tb/tb_csr_counter_file.sv
// Directed bench for csr_counter_file.
// Inputs change 1 time unit after a rising edge; reads are combinational.
module tb_csr_counter_file;

  logic        clk;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_src_zero;
  logic        retire;
  logic [1:0]  hpm_event;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  int n_chk;
  int n_fail;

  logic [31:0] d;
  logic        ill;

  csr_counter_file #(
    .XLEN(32),
    .CNT_W(64),
    .NUM_HPM(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_en      (csr_en),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_src_zero(csr_src_zero),
    .retire      (retire),
    .hpm_event   (hpm_event),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_en       = 1'b0;
    csr_op       = 2'b00;
    csr_wdata    = '0;
    csr_src_zero = 1'b0;
  endtask

  // csrrs rd, addr, x0: read only, no edge consumed.
  task automatic csr_rd(
    input  logic [11:0] a,
    output logic [31:0] v
  );
    csr_en       = 1'b1;
    csr_op       = 2'b10;
    csr_addr     = a;
    csr_wdata    = '0;
    csr_src_zero = 1'b1;
    #1;
    v = csr_rdata;
    idle();
  endtask

  // Access held across one rising edge.
  task automatic csr_wr(
    input  logic [1:0]  op,
    input  logic [11:0] a,
    input  logic [31:0] v,
    input  logic        zero,
    output logic        il
  );
    csr_en       = 1'b1;
    csr_op       = op;
    csr_addr     = a;
    csr_wdata    = v;
    csr_src_zero = zero;
    #1;
    il = csr_illegal;
    tick();
    idle();
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    retire    = 1'b0;
    hpm_event = '0;
    csr_addr  = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // First cycle after release reads 0, next reads 1.
    csr_rd(12'hB00, d); chk("rst_mcycle", d, 32'd0);
    csr_rd(12'hB80, d); chk("rst_mcycleh", d, 32'd0);
    csr_rd(12'hB02, d); chk("rst_minstret", d, 32'd0);
    csr_rd(12'h320, d); chk("rst_inhibit", d, 32'd0);
    csr_rd(12'h340, d); chk("rst_scratch", d, 32'd0);
    tick();
    csr_rd(12'hC00, d); chk("cycle_1", d, 32'd1);
    repeat (9) tick();
    csr_rd(12'hC00, d); chk("cycle_10", d, 32'd10);
    csr_rd(12'hC01, d); chk("time_10", d, 32'd10);

    // Low write, high write (no increment), then two counts.
    csr_wr(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, ill);
    csr_wr(2'b01, 12'hB80, 32'h0, 1'b0, ill);
    csr_rd(12'hB00, d); chk("lo_held", d, 32'hFFFF_FFFF);
    csr_rd(12'hB80, d); chk("hi_written", d, 32'h0);
    tick();
    tick();
    csr_rd(12'hB80, d); chk("carry_hi", d, 32'd1);
    csr_rd(12'hB00, d); chk("carry_lo", d, 32'd1);

    // Inhibit: the set edge still counts (1 -> 2).
    csr_wr(2'b10, 12'h320, 32'h1, 1'b0, ill);
    repeat (5) tick();
    csr_rd(12'hB00, d); chk("inh_frozen", d, 32'd2);
    csr_rd(12'h320, d); chk("inh_read", d, 32'h1);
    csr_wr(2'b11, 12'h320, 32'h1, 1'b0, ill);
    csr_rd(12'hB00, d); chk("inh_clr_edge", d, 32'd2);
    tick();
    csr_rd(12'hB00, d); chk("inh_resume", d, 32'd3);

    // Write beats a same-cycle retire.
    retire = 1'b1;
    csr_wr(2'b01, 12'hB02, 32'h100, 1'b0, ill);
    retire = 1'b0;
    csr_rd(12'hB02, d); chk("instret_wr", d, 32'h100);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    csr_rd(12'hC02, d); chk("instret_inc", d, 32'h101);

    // Event counters.
    hpm_event = 2'b01;
    tick();
    tick();
    hpm_event = 2'b10;
    tick();
    hpm_event = 2'b00;
    csr_rd(12'hB03, d); chk("hpm3", d, 32'd2);
    csr_rd(12'hC04, d); chk("hpm4", d, 32'd1);
    csr_rd(12'hB83, d); chk("hpm3h", d, 32'd0);

    // Scratch RMW and zero-source suppression.
    csr_wr(2'b01, 12'h340, 32'hA5, 1'b0, ill);
    csr_wr(2'b10, 12'h340, 32'hFF, 1'b1, ill);
    chk("rs_zero_ill", {31'd0, ill}, 32'd0);
    csr_rd(12'h340, d); chk("rs_zero_keep", d, 32'hA5);
    csr_wr(2'b11, 12'h340, 32'h05, 1'b0, ill);
    csr_rd(12'h340, d); chk("rc_scratch", d, 32'hA0);

    // Read-only write attempt leaves cycle alone.
    csr_wr(2'b10, 12'h320, 32'h1, 1'b0, ill);
    csr_wr(2'b01, 12'hB00, 32'h50, 1'b0, ill);
    csr_wr(2'b01, 12'hC00, 32'h1234, 1'b0, ill);
    chk("ro_wr_ill", {31'd0, ill}, 32'd1);
    csr_rd(12'hB00, d); chk("ro_no_write", d, 32'h50);
    csr_wr(2'b01, 12'hB05, 32'h1, 1'b0, ill);
    chk("hpm5_ill", {31'd0, ill}, 32'd1);
    csr_wr(2'b10, 12'hB04, 32'h0, 1'b1, ill);
    chk("hpm4_legal", {31'd0, ill}, 32'd0);
    csr_wr(2'b01, 12'hB01, 32'h1, 1'b0, ill);
    chk("b01_ill", {31'd0, ill}, 32'd1);
    csr_rd(12'h7C0, d); chk("unmapped_rd", d, 32'd0);

    // Inhibit hardwired bits.
    csr_wr(2'b01, 12'h320, 32'hFFFF_FFFF, 1'b0, ill);
    csr_rd(12'h320, d); chk("inh_mask", d, 32'h1D);
    csr_wr(2'b01, 12'h320, 32'h0, 1'b0, ill);

    // Disabled access: no write, no illegal.
    csr_en    = 1'b0;
    csr_op    = 2'b01;
    csr_addr  = 12'h340;
    csr_wdata = 32'h99;
    #1;
    chk("en0_ill", {31'd0, csr_illegal}, 32'd0);
    tick();
    idle();
    csr_rd(12'h340, d); chk("en0_no_wr", d, 32'hA0);

    // Reset mid-count with a pending scratch write.
    rst       = 1'b1;
    csr_en    = 1'b1;
    csr_op    = 2'b01;
    csr_addr  = 12'h340;
    csr_wdata = 32'h77;
    tick();
    idle();
    rst = 1'b0;
    csr_rd(12'h340, d); chk("rst2_scratch", d, 32'd0);
    csr_rd(12'hB00, d); chk("rst2_mcycle", d, 32'd0);
    csr_rd(12'hB02, d); chk("rst2_instret", d, 32'd0);
    csr_rd(12'hB03, d); chk("rst2_hpm3", d, 32'd0);
    csr_rd(12'h320, d); chk("rst2_inhibit", d, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_counter_file.md
CSR_COUNTER_FILE -- requirements
Module: csr_counter_file

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of csr_wdata/csr_rdata; only 32 is supported.
REQ-002 SHALL have parameter CNT_W, default 64: counter width; legal range 33..64.
REQ-003 SHALL have parameter NUM_HPM, default 2: number of event counters hpm3..hpm(2+NUM_HPM); legal range 0..8.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port csr_en, input, 1: a CSR instruction is in the access stage this cycle.
REQ-007 SHALL have port csr_op, input, 2: 00 none, 01 RW, 10 RS, 11 RC.
REQ-008 SHALL have port csr_addr, input, 12: CSR address.
REQ-009 SHALL have port csr_wdata, input, XLEN: rs1 value or zero-extended zimm.
REQ-010 SHALL have port csr_src_zero, input, 1: rs1 is x0 or zimm is 0.
REQ-011 SHALL have port retire, input, 1: one instruction retires this cycle.
REQ-012 SHALL have port hpm_event, input, NUM_HPM (minimum 1 bit): per-counter event pulses.
REQ-013 SHALL have port csr_rdata, output, XLEN: old CSR value.
REQ-014 SHALL have port csr_illegal, output, 1: the access is illegal.

Function
REQ-015 SHALL map mcycle/mcycleh to 0xB00/0xB80, minstret/minstreth to 0xB02/0xB82, mhpmcounterN/h to 0xB00+N/0xB80+N, cycle/time/instret to 0xC00/0xC01/0xC02 with high halves at +0x80, hpmcounterN to 0xC00+N, mcountinhibit to 0x320, and mscratch to 0x340.
REQ-016 SHALL drive csr_rdata combinationally in the same cycle; low half = counter[31:0], high half = counter[CNT_W-1:32] zero-extended; time SHALL alias cycle; unmapped reads SHALL return 0.
REQ-017 SHALL compute the new value as RW: wdata; RS: old|wdata; RC: old&~wdata, and commit it at the next rising clk edge.
REQ-018 SHALL suppress the write when op is RS or RC and csr_src_zero=1; the read still occurs.
REQ-019 SHALL assert csr_illegal combinationally when csr_en=1 and the address is unmapped, or hpm index ≥ 3+NUM_HPM, or the access writes a 0xCxx read-only address; csr_illegal SHALL be 0 when csr_en=0.
REQ-020 SHALL not change any state on an illegal access.
REQ-021 SHALL increment mcycle by 1 every cycle unless mcountinhibit[0]=1.
REQ-022 SHALL increment minstret when retire=1 and mcountinhibit[2]=0.
REQ-023 SHALL increment hpmN when hpm_event[N-3]=1 and mcountinhibit[N]=0.
REQ-024 SHALL wrap all counters from all-ones to 0 with no flag.
REQ-025 SHALL keep mcountinhibit bit 1 and bits above 2+NUM_HPM hardwired to 0.
REQ-026 SHALL, when a counter is written and would increment in the same cycle, load the written value with no increment that cycle.
REQ-027 SHALL leave the high half unchanged on a low-half write, and the low half unchanged on a high-half write.
REQ-028 SHALL ignore csr_en=0 and csr_op=00 (no write, csr_illegal=0).

Reset
REQ-029 SHALL, when rst=1 at a clock edge, clear all counters, mcountinhibit and mscratch to 0 and discard any same-cycle write or increment.
REQ-030 SHALL read mcycle as 0 in the first cycle after reset is released and as 1 in the next cycle.

Structure
REQ-031 SHALL place the CSR address localparams and the csr_op enum (CSR_NONE, CSR_RW, CSR_RS, CSR_RC) in shared package csr_pkg.
REQ-032 SHALL instantiate one sub-module per counter, csr_counter (parameter CNT_W; inputs inc, wr_lo, wr_hi, wdata; output count), used for cycle, instret and each hpm.

Verification
REQ-033 Reset, then idle 10 cycles, then csrr 0xC00 -> rdata=10 (±0 with exact alignment documented in the bench); 0xC01 returns the same value.
REQ-034 RW 0xB00 with 0xFFFFFFFF, then RW 0xB80 with 0 -> after two cycles, cycleh=1 and cycle=1 (carry check).
REQ-035 RS 0x320 with 0x1, then idle 5 cycles -> mcycle unchanged; RC 0x320 with 0x1 -> counting resumes.
REQ-036 retire=1 and RW 0xB02 with 0x100 in the same cycle -> minstret=0x100 the next cycle, not 0x101.
REQ-037 RS 0x340 with csr_src_zero=1 -> mscratch unchanged, csr_illegal=0; RW 0xC00 -> csr_illegal=1 and cycle not written; with NUM_HPM=2, access to 0xB05 -> csr_illegal=1.
REQ-038 Assert rst mid-count with a pending RW to mscratch -> all reads return 0 after reset.
